attribute_residual_encoder: RTL
===============================

ATTRIBUTE_RESIDUAL_ENCODER -- requirements
Module: attribute_residual_encoder

Interface
REQ-001 Parameter ATTR_WIDTH, default 8: unsigned attribute width and signed residual width.
REQ-002 Parameter CNT_WIDTH, default 16: width of the clip event counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input sample valid.
REQ-006 in_ready  output  1  block can accept an input sample.
REQ-007 in_attr  input  ATTR_WIDTH  actual unsigned attribute value.
REQ-008 in_first  input  1  sample is first of a point cloud; restart predictor.
REQ-009 out_valid  output  1  output residual valid.
REQ-010 out_ready  input  1  downstream accepts output.
REQ-011 out_residual  output  ATTR_WIDTH signed  residual for the decoder-side combiner.
REQ-012 out_pred  output  ATTR_WIDTH  predictor used for this sample.
REQ-013 out_first  output  1  in_first registered with the sample.
REQ-014 out_clip  output  1  residual was clamped for this sample.
REQ-015 clip_count  output  CNT_WIDTH  saturating count of clamped samples.
REQ-016 clear_count  input  1  synchronous clear of clip_count.

Function
REQ-017 The block SHALL accept a sample on a clk edge where in_valid && in_ready ("accept").
REQ-018 in_ready SHALL equal !out_valid || out_ready (single output register, no combinational path from in_valid).
REQ-019 Predictor for an accepted sample SHALL be MID = 2**(ATTR_WIDTH-1) when in_first=1, else recon_reg.
REQ-020 diff SHALL be computed in ATTR_WIDTH+1 signed bits as in_attr - predictor.
REQ-021 Residual SHALL be diff clamped to [-2**(ATTR_WIDTH-1), 2**(ATTR_WIDTH-1)-1]; out_clip=1 iff clamping occurred.
REQ-022 recon = predictor + residual; it is always within [0, 2**ATTR_WIDTH-1]; recon_reg SHALL load recon on accept, matching the decoder combiner bit-exactly with its overflow flag never set.
REQ-023 Latency SHALL be 1 cycle: on accept, out_residual/out_pred/out_first/out_clip load and out_valid=1 on the same edge.
REQ-024 When out_valid && out_ready and no accept, out_valid SHALL clear next edge; output fields SHALL hold their last values.
REQ-025 While out_valid && !out_ready, all output fields and recon_reg SHALL remain stable.
REQ-026 Simultaneous output handoff and accept SHALL replace the output with the new sample, out_valid staying 1 (full throughput, one sample/cycle).
REQ-027 clip_count SHALL increment by 1 on each accept with clamping, saturating at 2**CNT_WIDTH-1.
REQ-028 clear_count=1 SHALL set clip_count to 0 next edge, taking priority over a simultaneous increment.
REQ-029 in_first with in_valid=0 SHALL have no effect.

Reset
REQ-030 On rst_n=0, immediately: out_valid=0, out_residual=0, out_pred=0, out_first=0, out_clip=0, clip_count=0, recon_reg=MID; in_ready=1 follows.
REQ-031 Reset asserted mid-stream SHALL discard any pending output; the first sample after reset uses MID as predictor even if in_first=0.

Verification (ATTR_WIDTH=8, MID=128, out_ready=1 unless noted)
REQ-032 Accept in_first=1, in_attr=200 -> next cycle out_residual=72, out_pred=128, out_clip=0, out_first=1.
REQ-033 Then in_attr=10 -> out_residual=-128, out_pred=200, out_clip=1, clip_count=1; then in_attr=250 -> out_residual=127, out_pred=72, out_clip=1, clip_count=2.
REQ-034 Hold out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0, outputs and clip_count unchanged; out_ready=1 -> back-to-back accepts, no sample lost or duplicated.
REQ-035 clip_count at 65535 plus a clipped accept -> remains 65535; clear_count coincident with a clipped accept -> clip_count=0.
REQ-036 Drop rst_n mid-stream with out_valid=1 -> out_valid=0 asynchronously; after release, in_attr=100 with in_first=0 -> out_residual=-28, out_pred=128.
REQ-037 Random stream fed through this block and the decoder combiner -> reconstructed attributes equal encoder recon for every sample.

Source files
------------

// File: rtl/attribute_residual_encoder.sv
// Attribute residual encoder: predicts each attribute from the previous reconstruction,
// emits a clamped signed residual through a single valid/ready output register.
module attribute_residual_encoder #(
  parameter int ATTR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ATTR_WIDTH-1:0]        in_attr,
  input  logic                         in_first,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ATTR_WIDTH-1:0] out_residual,
  output logic [ATTR_WIDTH-1:0]        out_pred,
  output logic                         out_first,
  output logic                         out_clip,
  output logic [CNT_WIDTH-1:0]         clip_count,
  input  logic                         clear_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // output register frees up when it is empty or being drained this cycle.
  localparam logic [ATTR_WIDTH-1:0]        MID     = {1'b1, {(ATTR_WIDTH-1){1'b0}}};
  localparam logic signed [ATTR_WIDTH:0]   RES_MAX = {2'b00, {(ATTR_WIDTH-1){1'b1}}};
  localparam logic signed [ATTR_WIDTH:0]   RES_MIN = {2'b11, {(ATTR_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]         CNT_MAX = '1;

  logic                         accept;
  logic [ATTR_WIDTH-1:0]        recon_reg;
  logic [ATTR_WIDTH-1:0]        pred;
  logic signed [ATTR_WIDTH:0]   diff;
  logic signed [ATTR_WIDTH-1:0] residual;
  logic                         clip;
  logic [ATTR_WIDTH-1:0]        recon;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign pred     = in_first ? MID : recon_reg;
  assign diff     = $signed({1'b0, in_attr}) - $signed({1'b0, pred});

  always_comb begin
    clip     = 1'b0;
    residual = diff[ATTR_WIDTH-1:0];
    if (diff > RES_MAX) begin
      residual = RES_MAX[ATTR_WIDTH-1:0];
      clip     = 1'b1;
    end else if (diff < RES_MIN) begin
      residual = RES_MIN[ATTR_WIDTH-1:0];
      clip     = 1'b1;
    end
  end

  // The true sum always lies in [0, 2**ATTR_WIDTH-1], so modular addition is exact.
  assign recon = pred + $unsigned(residual);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_residual <= '0;
      out_pred     <= '0;
      out_first    <= 1'b0;
      out_clip     <= 1'b0;
      recon_reg    <= MID;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_residual <= residual;
      out_pred     <= pred;
      out_first    <= in_first;
      out_clip     <= clip;
      recon_reg    <= recon;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (clear_count) begin
      clip_count <= '0;
    end else if (accept && clip && clip_count != CNT_MAX) begin
      clip_count <= clip_count + 1'b1;
    end
  end

endmodule
